axi_write: RTL
==============

Name: axi_write

Overview:
- AXI4 burst write master: the write-side counterpart of the stream-output burst reader.
- Accepts an AXI-Stream beat flow and writes it to memory as fixed-length INCR bursts of WR_LIN beats at a rolling address.
- Waits for each write response, then pulses o_wr_done. o_wr_done drives the reader's start input (i_wr_done).
- Single clock domain: the stream side and the AXI side share one clock.

Parameters:
- WR_FLIP_BYTE, 0, 1 = byte-reverse each stream word before it goes onto wdata.
- WR_ADDR_WIDTH, 32, AXI address width.
- WR_DATA_WIDTH, 64, data width; legal values 32, 64, 128.
- WR_LIN, 16, beats per burst (1-256).
- WR_BASE_ADDR, 32'h0, first burst address and wrap target.
- WR_ADDR_STEP, 4096, address increment per burst in bytes.
- WR_ADDR_LIMIT, 32'h10000, wrap bound (exclusive).

Ports:
- S_WR_aclk  in  1  clock for all logic.
- S_WR_areset  in  1  synchronous reset, active-high.
- S_WR_tdata  in  WR_DATA_WIDTH  stream data.
- S_WR_tvalid  in  1  stream valid.
- S_WR_tlast  in  1  stream last; informational only (see Optional Feature).
- S_WR_tready  out  1  stream ready.
- o_wr_done  out  1  one-cycle pulse after a burst's OKAY/any response is accepted.
- o_wr_err  out  1  sticky response error flag (see Optional Feature).
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid  out  1/WR_ADDR_WIDTH/8/3/2/1/4/3/4/1  AXI write address channel.
- m_axi_awready  in  1  AXI write address ready.
- m_axi_wdata/wstrb/wlast/wvalid  out  WR_DATA_WIDTH/WR_DATA_WIDTH/8/1/1  AXI write data channel.
- m_axi_wready  in  1  AXI write data ready.
- m_axi_bid/bresp/bvalid  in  1/2/1  AXI write response channel.
- m_axi_bready  out  1  AXI write response ready.

Behaviour:
- Constants:
  - awid=0, awlock=0, awcache=4'd3, awprot=0, awqos=0, awburst=2'd1 (INCR).
  - awlen=WR_LIN-1, awsize=clog2(WR_DATA_WIDTH/8), wstrb all ones.
- Reset (sync, S_WR_areset=1 at clock edge): state=IDLE, awvalid=0, awaddr=0, wvalid=0, wlast=0, bready=0, S_WR_tready=0, o_wr_done=0, o_wr_err=0, beat counter=0, address buffer=WR_BASE_ADDR.
- Reset mid-burst aborts immediately (AXI transaction abandoned by design) and the next burst restarts at WR_BASE_ADDR.
- FSM:
  - IDLE: go to WR_ADDR when S_WR_tvalid=1. Register awaddr<=address buffer.
  - WR_ADDR: awvalid=1, held until awready; on handshake go to WR_DATA. awvalid must not drop before the handshake.
  - WR_DATA: combinational pass-through, zero latency.
    - wvalid=S_WR_tvalid, S_WR_tready=m_axi_wready, wdata=S_WR_tdata (optionally flipped).
    - Beat counter increments on wvalid&&wready.
    - wlast=1 exactly when counter==WR_LIN-1. When the last beat is accepted, clear the counter and go to WR_RESP.
  - WR_RESP: bready=1; on bvalid go to WR_DONE.
  - WR_DONE: one cycle; o_wr_done=1.
    - Address buffer advances: if buffer >= WR_ADDR_LIMIT-WR_ADDR_STEP then WR_BASE_ADDR, else buffer+WR_ADDR_STEP.
    - Return to IDLE.
- Outside WR_DATA: S_WR_tready=0, wvalid=0, wlast=0. No stream beat is consumed outside WR_DATA.
- WR_LIN=1: first accepted beat carries wlast=1.
- Gaps: tvalid gaps or wready stalls inside a burst only pause the counter; beats are never dropped or duplicated.
- Minimum idle between bursts: WR_DONE plus IDLE, 2 cycles.
- No outstanding-transaction overlap: one burst in flight at a time.

Optional Feature:
- Macro AXI_WR_RESP_CHECK_EN.
- Defined:
  - o_wr_err is set when bvalid&&bready and bresp!=2'b00, and also when an accepted stream beat has S_WR_tlast=1 while counter!=WR_LIN-1.
  - o_wr_err is sticky until reset. o_wr_done still pulses.
- Undefined: o_wr_err is tied 0; bresp and S_WR_tlast are ignored.

Test Plan:
- Basic: WR_LIN=16, 64-bit, tvalid held 1, awready/wready/bvalid immediate -> awaddr=0x0, awlen=15, awsize=3; 16 beats accepted; wlast on beat 16 only; o_wr_done single pulse; second burst awaddr=0x1000.
- Backpressure: wready toggling 1/0 every cycle and tvalid random 50% -> exactly 16 beats, data order preserved, wlast on the 16th accepted beat, no tready outside WR_DATA.
- Stalls: awready delayed 5 cycles and bvalid delayed 7 cycles -> awvalid held stable 5 cycles; no beats taken before the AW handshake; o_wr_done only after bvalid.
- Wrap: 16 consecutive bursts -> addresses 0x0000..0xF000, 17th burst at 0x0000.
- Reset and flip: sync reset asserted at beat 7 -> all outputs zero next cycle, next burst awaddr=WR_BASE_ADDR. WR_FLIP_BYTE=1, tdata=64'h0102030405060708 -> wdata=64'h0807060504030201.
- Macro: with AXI_WR_RESP_CHECK_EN, bresp=2'b10 -> o_wr_err=1 after the handshake and stays 1; without the macro o_wr_err stays 0.

Source files
------------

// File: rtl/axi_write.sv
// AXI4 burst write master: streams WR_LIN-beat INCR bursts to a rolling address, pulses o_wr_done per response.
// Optional define AXI_WR_RESP_CHECK_EN enables the sticky o_wr_err response/tlast checker.
module axi_write #(
   parameter int          WR_FLIP_BYTE  = 0,
   parameter int          WR_ADDR_WIDTH = 32,
   parameter int          WR_DATA_WIDTH = 64,
   parameter int          WR_LIN        = 16,
   parameter logic [31:0] WR_BASE_ADDR  = 32'h0,
   parameter int          WR_ADDR_STEP  = 4096,
   parameter logic [31:0] WR_ADDR_LIMIT = 32'h10000
) (
   input  logic                       S_WR_aclk,
   input  logic                       S_WR_areset,
   input  logic [WR_DATA_WIDTH-1:0]   S_WR_tdata,
   input  logic                       S_WR_tvalid,
   input  logic                       S_WR_tlast,
   output logic                       S_WR_tready,
   output logic                       o_wr_done,
   output logic                       o_wr_err,
   output logic                       m_axi_awid,
   output logic [WR_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                 m_axi_awlen,
   output logic [2:0]                 m_axi_awsize,
   output logic [1:0]                 m_axi_awburst,
   output logic                       m_axi_awlock,
   output logic [3:0]                 m_axi_awcache,
   output logic [2:0]                 m_axi_awprot,
   output logic [3:0]                 m_axi_awqos,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [WR_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [WR_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic                       m_axi_bid,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready
);
   localparam int                       LP_NB   = WR_DATA_WIDTH / 8;
   localparam logic [7:0]               LP_LAST = 8'(WR_LIN - 1);
   localparam logic [2:0]               LP_SIZE = 3'($clog2(LP_NB));
   localparam logic [WR_ADDR_WIDTH-1:0] LP_BASE = WR_ADDR_WIDTH'(WR_BASE_ADDR);
   localparam logic [WR_ADDR_WIDTH-1:0] LP_STEP = WR_ADDR_WIDTH'(WR_ADDR_STEP);
   localparam logic [WR_ADDR_WIDTH-1:0] LP_WRAP = WR_ADDR_WIDTH'(WR_ADDR_LIMIT) - LP_STEP;

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP, ST_DONE} state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [7:0]                 r_cnt;
   logic [WR_ADDR_WIDTH-1:0]   r_addr_buf;
   logic [WR_ADDR_WIDTH-1:0]   r_awaddr;
   logic [WR_DATA_WIDTH-1:0]   w_data;
   logic                       w_beat;
   logic                       w_unused;

   function automatic logic [WR_DATA_WIDTH-1:0] flip_bytes(input logic [WR_DATA_WIDTH-1:0] d);
      logic [WR_DATA_WIDTH-1:0] f;
      f = '0;
      for (int i = 0; i < LP_NB; i++) begin
         f[8*i +: 8] = d[8*(LP_NB-1-i) +: 8];
      end
      return f;
   endfunction

   assign w_data   = (WR_FLIP_BYTE != 0) ? flip_bytes(S_WR_tdata) : S_WR_tdata;
   assign w_beat   = (r_state == ST_DATA) && S_WR_tvalid && m_axi_wready;
   assign w_unused = ^{m_axi_bid, m_axi_bresp, S_WR_tlast};

   assign m_axi_awid    = 1'b0;
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awlen   = LP_LAST;
   assign m_axi_awsize  = LP_SIZE;
   assign m_axi_awburst = 2'd1;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd3;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_wstrb   = {LP_NB{1'b1}};

   // State register
   always_ff @(posedge S_WR_aclk) begin
      if (S_WR_areset) r_state <= ST_IDLE;
      else             r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (S_WR_tvalid)                          w_next = ST_ADDR;
         ST_ADDR: if (m_axi_awready)                        w_next = ST_DATA;
         ST_DATA: if (w_beat && (r_cnt == LP_LAST))         w_next = ST_RESP;
         ST_RESP: if (m_axi_bvalid)                         w_next = ST_DONE;
         ST_DONE:                                           w_next = ST_IDLE;
         default:                                           w_next = ST_IDLE;
      endcase
   end

   // Output decode; the data channel is a zero-latency pass-through of the stream
   always_comb begin
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_wdata   = '0;
      m_axi_bready  = 1'b0;
      S_WR_tready   = 1'b0;
      o_wr_done     = 1'b0;
      case (r_state)
         ST_ADDR: m_axi_awvalid = 1'b1;
         ST_DATA: begin
            m_axi_wvalid = S_WR_tvalid;
            S_WR_tready  = m_axi_wready;
            m_axi_wlast  = (r_cnt == LP_LAST);
            m_axi_wdata  = w_data;
         end
         ST_RESP: m_axi_bready = 1'b1;
         ST_DONE: o_wr_done    = 1'b1;
         default: ;
      endcase
   end

   // Burst address latch, beat counter and rolling address with wrap
   always_ff @(posedge S_WR_aclk) begin
      if (S_WR_areset) begin
         r_awaddr   <= '0;
         r_addr_buf <= LP_BASE;
         r_cnt      <= 8'd0;
      end else begin
         if ((r_state == ST_IDLE) && S_WR_tvalid) r_awaddr <= r_addr_buf;
         if (w_beat) r_cnt <= (r_cnt == LP_LAST) ? 8'd0 : r_cnt + 8'd1;
         if (r_state == ST_DONE)
            r_addr_buf <= (r_addr_buf >= LP_WRAP) ? LP_BASE : r_addr_buf + LP_STEP;
      end
   end

`ifdef AXI_WR_RESP_CHECK_EN
   logic r_err;

   // Sticky error: non-OKAY response or tlast on a beat that is not the burst's last
   always_ff @(posedge S_WR_aclk) begin
      if (S_WR_areset) begin
         r_err <= 1'b0;
      end else if (((r_state == ST_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00)) ||
                   (w_beat && S_WR_tlast && (r_cnt != LP_LAST))) begin
         r_err <= 1'b1;
      end
   end

   assign o_wr_err = r_err;
`else
   assign o_wr_err = 1'b0;
`endif

endmodule
